// File: rtl/cartoon_prep.sv
// 3x3 window front end for the cartoon stylisation stage: two HSV line buffers,
// 1-2-1 Gaussian blur per channel, Sobel magnitude on V, and the raw window centre.
module cartoon_prep #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        pixel_valid,
    input  logic [23:0] pixel_in,
    output logic        out_valid,
    output logic [23:0] cartoon_blur,
    output logic [7:0]  cartoon_edge,
    output logic [23:0] center_out
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    function automatic logic [11:0] kernel_sum(input logic [7:0] t0, t1, t2, m0, m1, m2, b0, b1, b2);
        return 12'(t0) + 12'(t2) + 12'(b0) + 12'(b2)
             + ((12'(t1) + 12'(m0) + 12'(m2) + 12'(b1)) << 1)
             + (12'(m1) << 2);
    endfunction

    // (p0 + 2*p1 + p2) - (n0 + 2*n1 + n2), range +/-1020
    function automatic logic signed [10:0] grad(input logic [7:0] n0, n1, n2, p0, p1, p2);
        logic [10:0] pos;
        logic [10:0] neg;
        pos = 11'(p0) + {2'b00, p1, 1'b0} + 11'(p2);
        neg = 11'(n0) + {2'b00, n1, 1'b0} + 11'(n2);
        return $signed(pos - neg);
    endfunction

    function automatic logic [10:0] mag_abs(input logic signed [10:0] g);
        return g[10] ? $unsigned(-g) : $unsigned(g);
    endfunction

    function automatic logic [7:0] blur_norm(input logic [11:0] s);
        return 8'(s >> 4);
    endfunction

    function automatic logic [7:0] sat_edge(input logic [10:0] mag);
        logic [10:0] q;
        q = mag >> 2;
        return (q > 11'd255) ? 8'hFF : q[7:0];
    endfunction

    logic [CW-1:0] col;
    logic [CW-1:0] pos_col;
    logic [RW-1:0] row;
    logic [RW-1:0] pos_row;

    // frame_start makes the pixel arriving in the same cycle position (0,0)
    assign pos_col = frame_start ? '0 : col;
    assign pos_row = frame_start ? '0 : row;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pixel_valid) begin
            if (pos_col == COL_LAST) begin
                col <= '0;
                row <= (pos_row == ROW_LAST) ? pos_row : pos_row + 1'b1;
            end else begin
                col <= pos_col + 1'b1;
                row <= pos_row;
            end
        end else if (frame_start) begin
            col <= '0;
            row <= '0;
        end
    end

    logic [23:0] lb1 [IMG_WIDTH];
    logic [23:0] lb2 [IMG_WIDTH];

    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            lb1[pos_col] <= pixel_in;
            lb2[pos_col] <= lb1[pos_col];
        end
    end

    // Stage 1: line-buffer read lands directly in the window's right column
    logic [23:0] win_p0 [3][3];
    logic        vld_p0;
    logic        outside_p0;
    logic        border_p0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0     <= 1'b0;
            outside_p0 <= 1'b0;
            border_p0  <= 1'b0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win_p0[i][j] <= '0;
        end else begin
            vld_p0 <= pixel_valid;
            if (pixel_valid) begin
                for (int i = 0; i < 3; i++) begin
                    win_p0[i][0] <= win_p0[i][1];
                    win_p0[i][1] <= win_p0[i][2];
                end
                win_p0[0][2] <= lb2[pos_col];
                win_p0[1][2] <= lb1[pos_col];
                win_p0[2][2] <= pixel_in;
                outside_p0   <= (pos_row == '0) || (pos_col == '0);
                border_p0    <= (pos_row == RW'(1)) || (pos_col == CW'(1));
            end
        end
    end

    // Stage 2: per-channel kernel sums and V gradients
    logic [11:0]        sum_p1 [3];
    logic signed [10:0] gx_p1;
    logic signed [10:0] gy_p1;
    logic [23:0]        centre_p1;
    logic               vld_p1;
    logic               outside_p1;
    logic               border_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            outside_p1 <= 1'b0;
            border_p1  <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                outside_p1 <= outside_p0;
                border_p1  <= border_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            for (int ch = 0; ch < 3; ch++)
                sum_p1[ch] <= kernel_sum(win_p0[0][0][ch*8 +: 8], win_p0[0][1][ch*8 +: 8], win_p0[0][2][ch*8 +: 8],
                                         win_p0[1][0][ch*8 +: 8], win_p0[1][1][ch*8 +: 8], win_p0[1][2][ch*8 +: 8],
                                         win_p0[2][0][ch*8 +: 8], win_p0[2][1][ch*8 +: 8], win_p0[2][2][ch*8 +: 8]);
            gx_p1 <= grad(win_p0[0][0][7:0], win_p0[1][0][7:0], win_p0[2][0][7:0],
                          win_p0[0][2][7:0], win_p0[1][2][7:0], win_p0[2][2][7:0]);
            gy_p1 <= grad(win_p0[0][0][7:0], win_p0[0][1][7:0], win_p0[0][2][7:0],
                          win_p0[2][0][7:0], win_p0[2][1][7:0], win_p0[2][2][7:0]);
            centre_p1 <= win_p0[1][1];
        end
    end

    // Stage 3: magnitude, normalise, saturate, border masking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            cartoon_blur <= '0;
            cartoon_edge <= '0;
            center_out   <= '0;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                if (outside_p1) begin
                    cartoon_blur <= '0;
                    cartoon_edge <= '0;
                    center_out   <= '0;
                end else if (border_p1) begin
                    cartoon_blur <= centre_p1;
                    cartoon_edge <= '0;
                    center_out   <= centre_p1;
                end else begin
                    cartoon_blur <= {blur_norm(sum_p1[2]), blur_norm(sum_p1[1]), blur_norm(sum_p1[0])};
                    cartoon_edge <= sat_edge(mag_abs(gx_p1) + mag_abs(gy_p1));
                    center_out   <= centre_p1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cartoon_prep.sv
// Directed bench for cartoon_prep: a reference window model fills a scoreboard
// queue as pixels are driven; outputs are popped and compared at their due cycle.
module tb_cartoon_prep;
    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        pixel_valid;
    logic [23:0] pixel_in;
    logic        out_valid;
    logic [23:0] cartoon_blur;
    logic [7:0]  cartoon_edge;
    logic [23:0] center_out;

    always #5 clk = ~clk;

    cartoon_prep #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pixel_valid(pixel_valid),
        .pixel_in(pixel_in), .out_valid(out_valid), .cartoon_blur(cartoon_blur),
        .cartoon_edge(cartoon_edge), .center_out(center_out)
    );

    typedef struct {
        logic [23:0] blur;
        logic [7:0]  edg;
        logic [23:0] center;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] img [H][W];
    int          m_col, m_row, cyc, n_checks, n_fail;

    function automatic exp_t model(input int r, input int c, input int due);
        exp_t e;
        int kb[9];
        int kx[9];
        int ky[9];
        int cr, cc, acc, gx, gy, mag, k, v;
        kb = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        kx = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        ky = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
        cr = r - 1;
        cc = c - 1;
        e.cyc = due; e.blur = '0; e.edg = '0; e.center = '0;
        if (r == 0 || c == 0) return e;
        e.center = img[cr][cc];
        if (cr == 0 || cc == 0 || cc == W - 1) begin
            e.blur = e.center;
            return e;
        end
        for (int ch = 0; ch < 3; ch++) begin
            acc = 0;
            for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++) begin
                    k = (dy + 1) * 3 + dx + 1;
                    acc += kb[k] * int'(img[cr+dy][cc+dx][ch*8 +: 8]);
                end
            e.blur[ch*8 +: 8] = 8'(acc / 16);
        end
        gx = 0; gy = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                k = (dy + 1) * 3 + dx + 1;
                v = int'(img[cr+dy][cc+dx][7:0]);
                gx += kx[k] * v;
                gy += ky[k] * v;
            end
        mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
        mag = mag / 4;
        e.edg = (mag > 255) ? 8'hFF : 8'(mag);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic sample();
        logic ev;
        exp_t e;
        ev = (sb.size() > 0) && (sb[0].cyc == cyc);
        check("out_valid", 32'(out_valid), 32'(ev));
        if (ev) begin
            e = sb.pop_front();
            if (out_valid === 1'b1) begin
                check("blur", 32'(cartoon_blur), 32'(e.blur));
                check("edge", 32'(cartoon_edge), 32'(e.edg));
                check("center", 32'(center_out), 32'(e.center));
            end
        end
    endtask

    task automatic check_zero();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_blur", 32'(cartoon_blur), 32'd0);
        check("rst_edge", 32'(cartoon_edge), 32'd0);
        check("rst_center", 32'(center_out), 32'd0);
    endtask

    task automatic tick(input logic fs, input logic pv, input logic [23:0] px);
        frame_start = fs;
        pixel_valid = pv;
        pixel_in    = px;
        if (fs) begin
            m_col = 0;
            m_row = 0;
        end
        if (pv && rst_n) begin
            img[m_row][m_col] = px;
            sb.push_back(model(m_row, m_col, cyc + 3));
            if (m_col == W - 1) begin
                m_col = 0;
                if (m_row < H - 1) m_row++;
            end else begin
                m_col++;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        sample();
    endtask

    function automatic logic [23:0] pattern(input int kind, input int r, input int c);
        case (kind)
            0: return 24'h80A040;
            1: return (c >= 4) ? 24'h0000FF : 24'h000000;
            2: return (r == 2 && c == 2) ? 24'h000040 : 24'h000000;
            3: return 24'h000010;
            default: return 24'($urandom);
        endcase
    endfunction

    // Sends npix pixels of a frame; gaps inserts random idle cycles.
    task automatic send_frame(input int kind, input int npix, input bit gaps);
        for (int i = 0; i < npix; i++) begin
            if (gaps) while ($urandom_range(0, 2) == 0) tick(1'b0, 1'b0, 24'h0);
            tick(i == 0, 1'b1, pattern(kind, i / W, i % W));
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; m_col = 0; m_row = 0;
        rst_n = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0; pixel_in = '0;
        tick(1'b0, 1'b0, 24'h0);
        tick(1'b0, 1'b0, 24'h0);
        check_zero();
        rst_n = 1'b1;

        // Reset mid-line with pixels still streaming
        send_frame(4, 13, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        m_col = 0; m_row = 0;
        tick(1'b0, 1'b1, 24'h123456);
        check_zero();
        tick(1'b0, 1'b1, 24'h654321);
        check_zero();
        rst_n = 1'b1;
        for (int i = 0; i < W * H; i++) begin
            tick(1'b0, 1'b1, 24'($urandom));
            if (i < 2) check_zero();
        end

        // Flat, vertical step and impulse frames back to back
        send_frame(0, W * H, 1'b0);
        send_frame(1, W * H, 1'b0);
        send_frame(2, W * H, 1'b0);

        // Valid pattern 1,0,0,1,1 starting at frame_start
        tick(1'b1, 1'b1, 24'h0A0B0C);
        tick(1'b0, 1'b0, 24'h0);
        tick(1'b0, 1'b0, 24'h0);
        tick(1'b0, 1'b1, 24'h0D0E0F);
        tick(1'b0, 1'b1, 24'h101112);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 24'h0);

        // Restart at (3,5) of a flat frame into a new flat frame
        send_frame(0, 3 * W + 5, 1'b0);
        send_frame(3, W * H, 1'b0);

        // Random content, contiguous then with gaps
        send_frame(4, W * H, 1'b0);
        send_frame(4, W * H, 1'b1);

        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 24'h0);
        check("drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cartoon_prep.md
# cartoon_prep

Window-filter front end that produces the `cartoon_blur` and `cartoon_edge` operands consumed by the cartoon stylisation stage. It takes the camera pixel stream in 24-bit HSV form (H[23:16], S[15:8], V[7:0]) and buffers two lines. On that stream it builds a 3×3 window and emits three aligned outputs:
- a 1-2-1 Gaussian-blurred pixel;
- a Sobel edge magnitude of the V channel;
- the raw window-centre pixel, which feeds the cartoon stage's `pixel_in` path.

## Interface
- IMG_WIDTH, 640, pixels per line (≥4)
- IMG_HEIGHT, 480, lines per frame (≥4)
- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- frame_start  in  1  start-of-frame pulse; qualifies nothing by itself
- pixel_valid  in  1  pixel_in is a new pixel this cycle
- pixel_in  in  24  HSV pixel
- out_valid  out  1  outputs below carry a new result
- cartoon_blur  out  24  per-channel 3×3 blur of window centre
- cartoon_edge  out  8  saturated Sobel magnitude of V
- center_out  out  24  raw window-centre pixel

## Operation
- **Position counters.**
  - col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1 on each pixel_valid. col wraps to 0 and row increments.
  - row saturates at IMG_HEIGHT-1.
  - frame_start forces col=row=0. If pixel_valid is high in the same cycle, that pixel is (0,0) and the counters then advance to col=1.
  - frame_start mid-frame restarts the counters; stale line-buffer data is masked by the row rules below.
- **Line buffers.** Two IMG_WIDTH×24 synchronous RAMs hold rows r-1 and r-2, addressed by col. They are written on pixel_valid and are never reset.
- **Window.** A 3×3 register window shifts by one column per pixel_valid only. When input (r,c) arrives, the window centre is (r-1, c-1).
- **Centre outside image** (r=0 or c=0): center_out = 0, cartoon_blur = 0, cartoon_edge = 0. out_valid is still asserted, so output count equals input count.
- **Centre on image border** (centre row 0, centre col 0, or centre col IMG_WIDTH-1):
  - cartoon_edge = 0;
  - cartoon_blur = center_out;
  - neighbours outside the image are never used.
- **Blur** (interior centre): per 8-bit channel, kernel [1 2 1; 2 4 2; 1 2 1]. The 12-bit sum is shifted right by 4 (truncating), giving a result ≤ 255.
- **Edge** (interior centre), on V only:
  - Gx = (right column) − (left column), weighted 1,2,1;
  - Gy = (bottom row) − (top row), weighted 1,2,1;
  - each is signed 11-bit, range ±1020;
  - mag = |Gx| + |Gy|, 11-bit, ≤ 2040;
  - cartoon_edge = min(255, mag >> 2).
- **Reset.**
  - All outputs are 0 and out_valid is 0.
  - Counters, window and pipeline valid bits are cleared.
  - Reset mid-frame discards all in-flight results. The first pixel after reset is treated as (0,0).

## Timing
- Fixed latency of 3 clocks: pixel_valid in cycle t gives out_valid in cycle t+3, carrying the result for the centre formed by that pixel.
  - Stage 1: RAM read and window shift.
  - Stage 2: per-channel partial sums and Gx/Gy.
  - Stage 3: absolute value, add, shift, saturate, output register.
- out_valid is pixel_valid delayed by 3. Gaps in pixel_valid appear unchanged at the output; there is no back-pressure.
- Output registers hold their last value while out_valid = 0.
- A row-to-row transition needs no idle cycles. Back-to-back pixels across the line wrap are legal.

## Test plan
Tests 2–6 use IMG_WIDTH=8 and IMG_HEIGHT=6.
1. **Reset.** Drive continuous valid pixels, then assert rst_n=0 for 2 cycles mid-line.
   - Required: out_valid=0 and all outputs 0 from the cycle after reset sampled, for 3 cycles after release.
   - The next pixel is counted as (0,0).
2. **Flat frame.** All pixels 0x80A040.
   - Interior centres: blur=0x80A040, edge=0x00.
   - Outputs with row 0 or col 0: all zero, out_valid=1.
3. **Vertical step.** V=0x00 for cols 0–3 and V=0xFF for cols 4–7, H=S=0.
   - Interior centre at col 3: Gx=1020, edge=0xFF.
   - Interior centre at col 4: Gx=1020, edge=0xFF.
   - Col 2: edge=0x00.
   - Blur V at col 3: (0+0+0+0+0+0+255·4)... per kernel, i.e. (255·(1+2+1))>>4 = 0x3F.
4. **Impulse.** V=0x40 at (2,2), all other pixels 0.
   - Blur V at centre (2,2) = 0x10; at (2,3) = 0x08; at (3,3) = 0x04.
   - Edge at (2,3) = (0x40·2)>>2 = 0x20.
5. **Latency and gaps.** frame_start with the first valid pixel, then a valid pattern 1,0,0,1,1.
   - Required: out_valid shows the same pattern exactly 3 cycles later.
6. **Mid-frame frame_start.** Assert at (3,5) with a new flat frame of 0x000010.
   - Required: the next outputs are zero for row 0/col 0 centres.
   - Interior edges are 0; no stale-row artefacts appear.
